serial_uart_bridge: RTL and testbench
=====================================

# serial_uart_bridge

Bridges the processor's byte-wide serial port to a pair of 8N1 UART pins. It sits directly downstream of the processor's `serial_*` pins:
- Processor writes (`serial_out`/`serial_wren_out`) are buffered and shifted out on `uart_tx_out`.
- Bytes received on `uart_rx_in` are buffered and presented back as `serial_in`/`serial_valid_in`, popped by `serial_rden_out`.

Both directions carry small FIFOs so the single-cycle core never stalls on line timing.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be ≥ 4.
- `FIFO_DEPTH`, default 4: entries per FIFO. Must be a power of 2, ≥ 2.
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `wr_data_in`  in  8: byte from the processor (`serial_out`).
- `wr_en_in`  in  1: write strobe (`serial_wren_out`), one cycle per byte.
- `wr_ready_out`  out  1: TX FIFO not full (`serial_ready_in`).
- `rd_en_in`  in  1: read/pop strobe (`serial_rden_out`).
- `rd_data_out`  out  8: RX FIFO head (`serial_in`).
- `rd_valid_out`  out  1: RX FIFO not empty (`serial_valid_in`).
- `uart_rx_in`  in  1: asynchronous serial line; idle high.
- `uart_tx_out`  out  1: serial line; idle high.
- `rx_overrun_out`  out  1: sticky; a received byte was dropped because the RX FIFO was full.
- `rx_frame_err_out`  out  1: sticky; a received byte had a low stop bit.

## Operation
- **Reset values:**
  - `uart_tx_out` = 1, `wr_ready_out` = 1.
  - `rd_valid_out` = 0, `rd_data_out` = 0.
  - Both sticky flags = 0.
  - FIFOs empty; both FSMs in IDLE.
  - The sticky flags are cleared only by reset.
- **FIFOs:**
  - Circular buffers with `log2(FIFO_DEPTH)`-bit pointers that wrap modulo the depth, plus a count register of `log2(FIFO_DEPTH)+1` bits.
  - `full` = (count == `FIFO_DEPTH`); `empty` = (count == 0).
  - Push and pop in the same cycle: both take effect and count is unchanged.
- **Processor write:** accepted iff `wr_en_in` && `wr_ready_out`. A write while full is silently dropped.
- **Processor read:** `rd_en_in` && `rd_valid_out` pops the head. `rd_en_in` while empty is ignored.
- **TX FSM:** IDLE → START → DATA → STOP.
  - *IDLE:* if the TX FIFO is non-empty, pop it into the shift register, zero the bit counter, and go to START.
  - *START:* drive 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - *DATA:* send 8 bits LSB-first, each for `CLKS_PER_BIT` cycles, then go to STOP.
  - *STOP:* drive 1 for `CLKS_PER_BIT` cycles. On the last cycle, if the FIFO is non-empty, pop and go straight to START (no gap); otherwise go to IDLE.
  - `uart_tx_out` is driven from a register.
- **RX FSM:** IDLE → START → DATA → STOP.
  - `uart_rx_in` passes through a 2-flop synchronizer before the FSM sees it.
  - *IDLE:* a synchronized 0 moves the FSM to START.
  - *START:* wait `CLKS_PER_BIT/2` cycles, then resample. If 1 (glitch), return to IDLE; if 0, go to DATA.
  - *DATA:* sample every `CLKS_PER_BIT` cycles, shifting 8 bits LSB-first.
  - *STOP:* sample after `CLKS_PER_BIT` cycles.
    - If 1 and the FIFO is not full: push the byte.
    - If 1 and the FIFO is full: set `rx_overrun_out` and discard the byte.
    - If 0: set `rx_frame_err_out`, discard the byte, and wait for the line to go high before returning to IDLE.
  - The baud counter is `log2(CLKS_PER_BIT)+1` bits wide and reloads on every state change.

## Timing
- **Write to TX start:** write accepted at edge N → FIFO holds the byte after N → FSM pops at edge N+1 → `uart_tx_out` = 0 after edge N+2 (when the FIFO and FSM were idle).
- **Frame length:** exactly 10·`CLKS_PER_BIT` cycles. Back-to-back frames have no idle cycles between the stop bit and the next start bit.
- **`wr_ready_out`:** combinational from count.
  - Falls the cycle after the write that fills the FIFO.
  - Rises the cycle after a TX pop from full.
  - A write in the same cycle as a pop from full is dropped, because ready was low.
- **`rd_data_out`/`rd_valid_out`:** combinational from RX FIFO state.
  - Valid the cycle after the STOP-sample edge that pushes the byte.
  - After a pop, the next entry (or valid = 0) appears the following cycle.
- **RX latency:** a start-bit falling edge on the pin to push is 2 synchronizer cycles + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`, ±1 cycle.
- **Reset mid-frame:** `uart_tx_out` goes to 1 asynchronously, any partial RX byte is discarded, and the FIFOs are emptied.

## Test plan
Use `CLKS_PER_BIT` = 4, `FIFO_DEPTH` = 4.
- **Single TX:** write 0xA5 → `uart_tx_out` carries 0, 1,0,1,0,0,1,0,1, 1, 4 cycles per bit, starting at edge N+2.
- **TX full/backpressure:** write 0x01..0x06 on consecutive cycles →
  - `wr_ready_out` falls once the FIFO is full.
  - Bytes written while ready is low are dropped; exactly the accepted bytes appear on the line, in order.
  - Frames are back-to-back, 40 cycles each.
- **Loopback RX:** tie `uart_tx_out` to `uart_rx_in`, write 0x3C → `rd_valid_out` = 1, `rd_data_out` = 0x3C. A single-cycle `rd_en_in` clears valid; no flags set.
- **RX overrun:** drive 5 frames 0x10..0x14 with no reads → FIFO holds 0x10..0x13, `rx_overrun_out` = 1, and reads return 0x10..0x13 in order.
- **RX errors:**
  - A 1-cycle low glitch on an idle line → no push, no flags.
  - A frame with stop bit = 0 → `rx_frame_err_out` = 1, no push.
- **Reset mid-frame:** assert `reset` 15 cycles into TX of 0xFF → `uart_tx_out` = 1 immediately, `wr_ready_out` = 1, `rd_valid_out` = 0, and no further frame is sent after release.

Source files
------------

// File: rtl/serial_uart_bridge.sv
// Byte-wide processor serial port <-> 8N1 UART bridge.
// TX and RX each buffer through a small circular FIFO so the core never waits on line timing.

module serial_uart_bridge_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module serial_uart_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] wr_data_in,
  input  logic       wr_en_in,
  output logic       wr_ready_out,
  input  logic       rd_en_in,
  output logic [7:0] rd_data_out,
  output logic       rd_valid_out,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);
  localparam int BW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  // ---------------- TX path ----------------
  logic       tx_fifo_pop, tx_fifo_full, tx_fifo_empty;
  logic [7:0] tx_fifo_head;

  serial_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_en_in),
    .push_data (wr_data_in),
    .pop       (tx_fifo_pop),
    .full      (tx_fifo_full),
    .empty     (tx_fifo_empty),
    .head      (tx_fifo_head)
  );

  assign wr_ready_out = !tx_fifo_full;

  tx_state_t     tx_state, tx_next;
  logic [BW-1:0] tx_baud;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_q, tx_line, tx_bit_done;

  assign tx_bit_done = (tx_baud == BAUD_LAST);
  assign uart_tx_out = tx_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (!tx_fifo_empty) tx_next = TX_START;
      TX_START: if (tx_bit_done) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_done && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_bit_done) tx_next = tx_fifo_empty ? TX_IDLE : TX_START;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_fifo_pop = 1'b0;
    tx_line     = 1'b1;
    case (tx_state)
      TX_IDLE:  tx_fifo_pop = !tx_fifo_empty;
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_shift[0];
      TX_STOP:  tx_fifo_pop = tx_bit_done && !tx_fifo_empty;
      default:  ;
    endcase
  end

  // Line bit is registered one cycle behind the state so the pin is glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_q     <= 1'b1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_q <= tx_line;
      if (tx_next != tx_state || tx_bit_done || tx_state == TX_IDLE) tx_baud <= '0;
      else                                                          tx_baud <= tx_baud + 1'b1;
      if (tx_fifo_pop) begin
        tx_shift <= tx_fifo_head;
        tx_bit   <= '0;
      end else if (tx_state == TX_DATA && tx_bit_done) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 1'b1;
      end
    end
  end

  // ---------------- RX path ----------------
  logic [1:0] rx_sync;
  logic       rx_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], uart_rx_in};
  end
  assign rx_s = rx_sync[1];

  rx_state_t     rx_state, rx_next;
  logic [BW-1:0] rx_baud;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_half, rx_done;
  logic          rx_push, rx_full, rx_empty, set_ovr, set_ferr;

  serial_uart_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rd_en_in),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rd_data_out)
  );

  assign rd_valid_out = !rx_empty;
  assign rx_half      = (rx_baud == BAUD_HALF);
  assign rx_done      = (rx_baud == BAUD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_s) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_done && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_done) rx_next = rx_s ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (rx_s) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push  = 1'b0;
    set_ovr  = 1'b0;
    set_ferr = 1'b0;
    if (rx_state == RX_STOP && rx_done) begin
      rx_push  = rx_s && !rx_full;
      set_ovr  = rx_s && rx_full;
      set_ferr = !rx_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_baud          <= '0;
      rx_bit           <= '0;
      rx_shift         <= '0;
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= 1'b0;
    end else begin
      if (rx_next != rx_state || (rx_state == RX_DATA && rx_done)) rx_baud <= '0;
      else                                                         rx_baud <= rx_baud + 1'b1;
      if (rx_state == RX_IDLE) begin
        rx_bit <= '0;
      end else if (rx_state == RX_DATA && rx_done) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      if (set_ovr)  rx_overrun_out   <= 1'b1;
      if (set_ferr) rx_frame_err_out <= 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_uart_bridge.sv
// Bench for serial_uart_bridge: TX line monitor + RX driver, both scored against expected-byte queues.

module tb_serial_uart_bridge;
  localparam int CPB = 4;
  localparam int DEPTH = 4;

  logic       clock, reset;
  logic [7:0] wr_data_in;
  logic       wr_en_in, wr_ready_out, rd_en_in;
  logic [7:0] rd_data_out;
  logic       rd_valid_out, uart_rx_in, uart_tx_out;
  logic       rx_overrun_out, rx_frame_err_out;
  logic       rx_drv, loop;

  assign uart_rx_in = loop ? uart_tx_out : rx_drv;

  serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .wr_data_in       (wr_data_in),
    .wr_en_in         (wr_en_in),
    .wr_ready_out     (wr_ready_out),
    .rd_en_in         (rd_en_in),
    .rd_data_out      (rd_data_out),
    .rd_valid_out     (rd_valid_out),
    .uart_rx_in       (uart_rx_in),
    .uart_tx_out      (uart_tx_out),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mcnt = -1;
  logic [9:0] mbits;
  int starts[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    logic       exp_ready;
  } wr_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Decodes frames off uart_tx_out by sampling each bit in its middle.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      mcnt = -1;
    end else begin
      if (mcnt < 0) begin
        if (uart_tx_out === 1'b0) begin
          mcnt = 0;
          starts.push_back(cyc);
        end
      end else begin
        mcnt++;
      end
      if (mcnt >= 0 && (mcnt % CPB) == CPB / 2) mbits[mcnt / CPB] = uart_tx_out;
      if (mcnt == 9 * CPB + CPB / 2) begin
        chk("tx_start_bit", {31'd0, mbits[0]}, 32'd0);
        chk("tx_stop_bit", {31'd0, mbits[9]}, 32'd1);
        if (tx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_frame: got byte %02h, required none", mbits[8:1]);
        end else begin
          chk("tx_byte", {24'd0, mbits[8:1]}, {24'd0, tx_exp.pop_front()});
        end
        mcnt = -1;
      end
    end
  end

  task automatic wait_tx_drain(input int budget);
    for (int i = 0; i < budget && (tx_exp.size() != 0 || mcnt >= 0); i++) @(negedge clock);
    chk("tx_drain", tx_exp.size(), 0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (CPB) @(negedge clock);
    end
    rx_drv = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic read_all();
    for (int n = 0; n < 2 * DEPTH + 2; n++) begin
      @(negedge clock);
      rd_en_in = 1'b0;
      if (!rd_valid_out) break;
      if (rx_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected_byte: got %02h, required none", rd_data_out);
      end else begin
        chk("rx_byte", {24'd0, rd_data_out}, {24'd0, rx_exp.pop_front()});
      end
      rd_en_in = 1'b1;
    end
    rd_en_in = 1'b0;
    chk("rx_left", rx_exp.size(), 0);
  endtask

  wr_vec_t bp_vec[7];
  int k, lowcnt;

  initial begin
    bp_vec[0] = '{1'b1, 8'h01, 1'b1};
    bp_vec[1] = '{1'b1, 8'h02, 1'b1};
    bp_vec[2] = '{1'b1, 8'h03, 1'b1};
    bp_vec[3] = '{1'b1, 8'h04, 1'b1};
    bp_vec[4] = '{1'b1, 8'h05, 1'b1};
    bp_vec[5] = '{1'b1, 8'h06, 1'b0};
    bp_vec[6] = '{1'b0, 8'h00, 1'b0};

    reset = 1'b1; wr_data_in = 8'h00; wr_en_in = 1'b0; rd_en_in = 1'b0;
    rx_drv = 1'b1; loop = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_tx", {31'd0, uart_tx_out}, 32'd1);
    chk("rst_ready", {31'd0, wr_ready_out}, 32'd1);
    chk("rst_valid", {31'd0, rd_valid_out}, 32'd0);
    chk("rst_rdata", {24'd0, rd_data_out}, 32'd0);
    chk("rst_ovr", {31'd0, rx_overrun_out}, 32'd0);
    chk("rst_ferr", {31'd0, rx_frame_err_out}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single TX with start latency
    starts.delete();
    wr_data_in = 8'hA5; wr_en_in = 1'b1; k = cyc;
    tx_exp.push_back(8'hA5);
    @(negedge clock);
    wr_en_in = 1'b0;
    wait_tx_drain(200);
    chk("tx_frames_single", starts.size(), 1);
    if (starts.size() > 0) chk("tx_start_latency", starts[0], k + 3);

    // Backpressure: table of consecutive writes
    starts.delete();
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      chk("wr_ready", {31'd0, wr_ready_out}, {31'd0, bp_vec[i].exp_ready});
      wr_data_in = bp_vec[i].data;
      wr_en_in   = bp_vec[i].wr_en;
      if (bp_vec[i].wr_en && bp_vec[i].exp_ready) tx_exp.push_back(bp_vec[i].data);
    end
    wr_en_in = 1'b0;
    wait_tx_drain(400);
    chk("wr_ready_after_drain", {31'd0, wr_ready_out}, 32'd1);
    chk("tx_frames_bp", starts.size(), 5);
    for (int i = 0; i + 1 < starts.size(); i++) chk("tx_frame_gap", starts[i+1] - starts[i], 10 * CPB);

    // Loopback
    @(negedge clock);
    loop = 1'b1;
    wr_data_in = 8'h3C; wr_en_in = 1'b1;
    tx_exp.push_back(8'h3C);
    @(negedge clock);
    wr_en_in = 1'b0;
    for (int i = 0; i < 200 && !rd_valid_out; i++) @(negedge clock);
    chk("lb_valid", {31'd0, rd_valid_out}, 32'd1);
    chk("lb_data", {24'd0, rd_data_out}, 32'h3C);
    rd_en_in = 1'b1;
    @(negedge clock);
    rd_en_in = 1'b0;
    chk("lb_valid_after_pop", {31'd0, rd_valid_out}, 32'd0);
    wait_tx_drain(100);
    loop = 1'b0;
    chk("lb_ovr", {31'd0, rx_overrun_out}, 32'd0);
    chk("lb_ferr", {31'd0, rx_frame_err_out}, 32'd0);

    // One-cycle glitch on idle line
    @(negedge clock);
    rx_drv = 1'b0;
    @(negedge clock);
    rx_drv = 1'b1;
    repeat (40) @(negedge clock);
    chk("glitch_valid", {31'd0, rd_valid_out}, 32'd0);
    chk("glitch_ovr", {31'd0, rx_overrun_out}, 32'd0);
    chk("glitch_ferr", {31'd0, rx_frame_err_out}, 32'd0);

    // Overrun: five frames, no reads
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) rx_exp.push_back(8'(8'h10 + i));
      send_frame(8'(8'h10 + i), 1'b1);
    end
    chk("ovr_valid", {31'd0, rd_valid_out}, 32'd1);
    chk("ovr_flag", {31'd0, rx_overrun_out}, 32'd1);
    chk("ovr_ferr", {31'd0, rx_frame_err_out}, 32'd0);
    read_all();

    // Frame error
    send_frame(8'h55, 1'b0);
    repeat (4) @(negedge clock);
    chk("ferr_flag", {31'd0, rx_frame_err_out}, 32'd1);
    chk("ferr_valid", {31'd0, rd_valid_out}, 32'd0);
    chk("ferr_ovr_sticky", {31'd0, rx_overrun_out}, 32'd1);

    // Reset 15 cycles into a frame of 0xFF with the TX FIFO full behind it
    @(negedge clock);
    k = cyc;
    for (int i = 0; i < 5; i++) begin
      wr_data_in = 8'hFF; wr_en_in = 1'b1;
      @(negedge clock);
    end
    wr_en_in = 1'b0;
    chk("mid_ready_full", {31'd0, wr_ready_out}, 32'd0);
    repeat (13) @(negedge clock);
    chk("mid_tx_busy", mcnt, 15);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_tx", {31'd0, uart_tx_out}, 32'd1);
    chk("mid_rst_ready", {31'd0, wr_ready_out}, 32'd1);
    chk("mid_rst_valid", {31'd0, rd_valid_out}, 32'd0);
    chk("mid_rst_ferr", {31'd0, rx_frame_err_out}, 32'd0);
    chk("mid_rst_ovr", {31'd0, rx_overrun_out}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    lowcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (uart_tx_out !== 1'b1) lowcnt++;
    end
    chk("no_frame_after_reset", lowcnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
